// File: rtl/rand_pos_gen.sv
// rtl/rand_pos_gen.sv - Fibonacci LFSR with request/response front end returning a random free grid cell
module rand_pos_gen #(
  parameter int              WIDTH        = 9,
  parameter logic [WIDTH-1:0] TAPS        = 9'h110,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 9'h001,
  parameter int              GRID_W       = 20,
  parameter int              GRID_H       = 15,
  parameter int              MAX_TRIES    = 64,
  localparam int             XW           = $clog2(GRID_W),
  localparam int             YW           = $clog2(GRID_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic             occ,
  output logic [WIDTH-1:0] rand_num,
  output logic [XW-1:0]    cand_x,
  output logic [YW-1:0]    cand_y,
  output logic             cand_vld,
  output logic [XW-1:0]    pos_x,
  output logic [YW-1:0]    pos_y,
  output logic             pos_vld,
  output logic             busy,
  output logic             fail
);

  // Retry counter only has to reach MAX_TRIES-1; the give-up happens on that attempt.
  localparam int CW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [CW-1:0] LAST_TRY = CW'(MAX_TRIES - 1);
  localparam logic [XW:0]   GW       = (XW+1)'(GRID_W);
  localparam logic [YW:0]   GH       = (YW+1)'(GRID_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [XW-1:0] draw_x;
  logic [YW-1:0] draw_y;
  logic          in_range;
  logic          clr_cnt, inc_cnt, take_cand, accept, give_up, attempt_bad;
  logic          feedback;

  assign feedback = ^(rand_num & TAPS);
  assign draw_x   = rand_num[XW-1:0];
  assign draw_y   = rand_num[XW+YW-1:XW];
  assign in_range = ({1'b0, draw_x} < GW) && ({1'b0, draw_y} < GH);
  assign cand_vld = (state == S_CHECK);
  assign busy     = (state != S_IDLE);

  // LFSR free-runs in every state; a reload overrides the shift and never lets zero in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rand_num <= DEFAULT_SEED;
    end else if (load) begin
      rand_num <= (seed == '0) ? DEFAULT_SEED : seed;
    end else begin
      rand_num <= {rand_num[WIDTH-2:0], feedback};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle control: draw, check, retry or give up.
  always_comb begin
    next_state  = state;
    clr_cnt     = 1'b0;
    inc_cnt     = 1'b0;
    take_cand   = 1'b0;
    accept      = 1'b0;
    give_up     = 1'b0;
    attempt_bad = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          next_state = S_DRAW;
          clr_cnt    = 1'b1;
        end
      end
      S_DRAW: begin
        if (in_range) begin
          take_cand  = 1'b1;
          next_state = S_CHECK;
        end else begin
          attempt_bad = 1'b1;
        end
      end
      S_CHECK: begin
        if (!occ) begin
          accept     = 1'b1;
          next_state = S_IDLE;
        end else begin
          attempt_bad = 1'b1;
          next_state  = S_DRAW;
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (attempt_bad) begin
      if (cnt == LAST_TRY) begin
        give_up    = 1'b1;
        next_state = S_IDLE;
      end else begin
        inc_cnt = 1'b1;
      end
    end
  end

  // Retry counter: cleared on a new request, bumped on every rejected attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (inc_cnt) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Candidate latch: holds the in-range draw while the occupancy map answers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_x <= '0;
      cand_y <= '0;
    end else if (take_cand) begin
      cand_x <= draw_x;
      cand_y <= draw_y;
    end
  end

  // Result registers: position held until the next accept, pulses last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x   <= '0;
      pos_y   <= '0;
      pos_vld <= 1'b0;
      fail    <= 1'b0;
    end else begin
      pos_vld <= accept;
      fail    <= give_up;
      if (accept) begin
        pos_x <= cand_x;
        pos_y <= cand_y;
      end
    end
  end

endmodule

// File: tb/tb_rand_pos_gen.sv
// tb/tb_rand_pos_gen.sv - directed self-checking bench for rand_pos_gen
module tb_rand_pos_gen;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [8:0] seed;
  logic       req;
  logic       occ;
  logic [8:0] rand_num;
  logic [4:0] cand_x;
  logic [3:0] cand_y;
  logic       cand_vld;
  logic [4:0] pos_x;
  logic [3:0] pos_y;
  logic       pos_vld;
  logic       busy;
  logic       fail;

  int checks = 0;
  int errors = 0;

  logic [8:0] m_rn;

  rand_pos_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .seed     (seed),
    .req      (req),
    .occ      (occ),
    .rand_num (rand_num),
    .cand_x   (cand_x),
    .cand_y   (cand_y),
    .cand_vld (cand_vld),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .pos_vld  (pos_vld),
    .busy     (busy),
    .fail     (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^9+x^5+1, zero seed replaced by 1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_rn <= 9'h001;
    else if (load) m_rn <= (seed == 9'h000) ? 9'h001 : seed;
    else m_rn <= {m_rn[7:0], m_rn[8] ^ m_rn[4]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  zeros, attempts, posc, failc, n;
  bit  done;

  initial begin
    rst_n = 1'b0; load = 1'b0; seed = 9'h000; req = 1'b0; occ = 1'b0;
    #23;
    // Reset values
    chk("rst_rand", 32'(rand_num), 32'h001);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cvld", 32'(cand_vld), 0);
    chk("rst_pvld", 32'(pos_vld), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_pos",  32'({pos_x, pos_y}), 0);
    chk("rst_cand", 32'({cand_x, cand_y}), 0);
    tick();
    rst_n = 1'b1;

    // 1: seed 1 then free-run sequence
    load = 1'b1; seed = 9'h001;
    tick();
    load = 1'b0;
    chk("seq0", 32'(rand_num), 32'h001);
    tick(); chk("seq1", 32'(rand_num), 32'h002);
    tick(); chk("seq2", 32'(rand_num), 32'h004);
    tick(); chk("seq3", 32'(rand_num), 32'h008);
    tick(); chk("seq4", 32'(rand_num), 32'h010);
    tick(); chk("seq5", 32'(rand_num), 32'h021);

    // 2: zero seed substitution and full period
    load = 1'b1; seed = 9'h000;
    tick();
    load = 1'b0;
    chk("zero_seed", 32'(rand_num), 32'h001);
    zeros = 0;
    for (int i = 0; i < 511; i++) begin
      tick();
      if (rand_num == 9'h000) zeros++;
    end
    chk("period_nozero", 32'(zeros), 0);
    chk("period_wrap", 32'(rand_num), 32'h001);
    chk("model_sync", 32'(rand_num), 32'(m_rn));

    // Minimum latency: load+req together, first draw (1,0) is in range and free
    occ = 1'b0;
    load = 1'b1; seed = 9'h001; req = 1'b1;
    tick();
    load = 1'b0; req = 1'b0;
    chk("lat_busy", 32'(busy), 1);
    chk("lat_cvld0", 32'(cand_vld), 0);
    tick();
    chk("lat_cvld1", 32'(cand_vld), 1);
    chk("lat_cand", 32'({cand_x, cand_y}), 32'({5'd1, 4'd0}));
    tick();
    chk("lat_pvld", 32'(pos_vld), 1);
    chk("lat_pos", 32'({pos_x, pos_y}), 32'({5'd1, 4'd0}));
    chk("lat_idle", 32'(busy), 0);
    tick();
    chk("lat_pulse", 32'(pos_vld), 0);

    // 4: three occupied checks then free
    load = 1'b1; seed = 9'h001; req = 1'b1;
    tick();
    load = 1'b0; req = 1'b0;
    tick();
    chk("r_c1", 32'({cand_vld, cand_x, cand_y}), 32'({1'b1, 5'd1, 4'd0}));
    occ = 1'b1;
    tick();
    chk("r_d1", 32'(cand_vld), 0);
    tick();
    chk("r_c2", 32'({cand_vld, cand_x, cand_y}), 32'({1'b1, 5'd4, 4'd0}));
    tick();
    chk("r_d2", 32'(cand_vld), 0);
    tick();
    chk("r_c3", 32'({cand_vld, cand_x, cand_y}), 32'({1'b1, 5'd16, 4'd0}));
    tick();
    chk("r_d3", 32'(rand_num), 32'h042);
    tick();
    chk("r_c4", 32'({cand_vld, cand_x, cand_y}), 32'({1'b1, 5'd2, 4'd2}));
    occ = 1'b0;
    tick();
    chk("r_pvld", 32'({pos_vld, fail, busy}), 32'b100);
    chk("r_pos", 32'({pos_x, pos_y}), 32'({5'd2, 4'd2}));

    // 3: 1000 requests with free grid
    occ = 1'b0;
    for (int r = 0; r < 1000; r++) begin
      req = 1'b1;
      tick();
      req = 1'b0;
      n = 0;
      posc = 0;
      while (busy && n < 300) begin
        tick();
        n++;
        if (pos_vld && busy) posc++;
      end
      chk("many_bound", 32'(n < 300), 1);
      chk("many_pvld", 32'({pos_vld, fail}), 32'b10);
      chk("many_rng", 32'((32'(pos_x) < 20) && (32'(pos_y) < 15)), 1);
      chk("many_early", 32'(posc), 0);
      tick();
      chk("many_once", 32'({pos_vld, busy}), 0);
    end

    // 5: always occupied -> fail after 64 attempts; req while busy ignored
    occ = 1'b1;
    load = 1'b1; seed = 9'h001; req = 1'b1;
    tick();
    load = 1'b0; req = 1'b0;
    attempts = 0; posc = 0; failc = 0; done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (pos_vld) posc++;
      if (fail) begin
        failc++;
        done = 1'b1;
      end else begin
        if (cand_vld) attempts++;
        else if (busy && !((32'(m_rn[4:0]) < 20) && (32'(m_rn[8:5]) < 15))) attempts++;
        req = (c == 30);
        tick();
      end
    end
    req = 1'b0;
    chk("fail_seen", 32'(failc), 1);
    chk("fail_tries", 32'(attempts), 64);
    chk("fail_nopos", 32'(posc), 0);
    chk("fail_idle", 32'(busy), 0);
    tick();
    chk("fail_pulse", 32'({fail, pos_vld, busy}), 0);
    tick(); tick();
    chk("fail_norerun", 32'(busy), 0);

    // 6: async reset during CHECK
    occ = 1'b0;
    load = 1'b1; seed = 9'h001; req = 1'b1;
    tick();
    load = 1'b0; req = 1'b0;
    tick();
    chk("ar_incheck", 32'(cand_vld), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rand", 32'(rand_num), 32'h001);
    chk("ar_ctrl", 32'({cand_vld, busy, pos_vld, fail}), 0);
    chk("ar_regs", 32'({cand_x, cand_y, pos_x, pos_y}), 0);
    tick();
    rst_n = 1'b1;
    posc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pos_vld || fail || busy) posc++;
    end
    chk("ar_nopulse", 32'(posc), 0);
    chk("ar_model", 32'(rand_num), 32'(m_rn));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
